// File: rtl/ram_sync_dp_be_if.sv
// Bus bundle for ram_sync_dp_be: write port, read port and status.
// The master drives requests; the slave (the RAM) returns data and status.
interface ram_sync_dp_be_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  localparam int NBYTES = DWIDTH / 8;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [NBYTES-1:0] wr_be;
  logic [DWIDTH-1:0] din;
  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] dout;
  logic              rd_valid;
  logic              ready;

  modport master (
    output wr_en, wr_addr, wr_be, din, rd_en, rd_addr,
    input  dout, rd_valid, ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, din, rd_en, rd_addr,
    output dout, rd_valid, ready
  );
endinterface

// File: rtl/ram_sync_dp_be.sv
// Simple-dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and a clear-on-reset
// sequencer that walks every address writing INIT_VALUE.
module ram_sync_dp_be #(
  parameter int              AWIDTH         = 3,
  parameter int              DWIDTH         = 32,
  parameter int              RDW_MODE       = 0,
  parameter int              OUT_REG        = 0,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DWIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  ram_sync_dp_be_if.slave  bus
);
  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [AWIDTH-1:0] r_clr_cnt;
  logic [AWIDTH-1:0] w_clr_cnt_next;
  logic              r_ready;
  logic              w_ready_next;

  logic              w_wr_accept;
  logic              w_rd_accept;
  logic              w_mem_we;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [NBYTES-1:0] w_mem_be;
  logic [DWIDTH-1:0] w_mem_din;
  logic [DWIDTH-1:0] w_rd_word;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_dout;
  logic              r_rd_valid;

  // Requests are honoured only while the ports are advertised as ready.
  assign w_wr_accept = r_ready & bus.wr_en;
  assign w_rd_accept = r_ready & bus.rd_en;

  // State, clear counter and ready flag registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
      r_ready   <= w_ready_next;
    end
  end

  // Next-state logic and selection of the memory write source.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_mem_we       = 1'b0;
    w_mem_addr     = bus.wr_addr;
    w_mem_be       = bus.wr_be;
    w_mem_din      = bus.din;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we       = 1'b1;
        w_mem_addr     = r_clr_cnt;
        w_mem_be       = '1;
        w_mem_din      = INIT_VALUE;
        w_clr_cnt_next = r_clr_cnt + 1'b1;
        if (r_clr_cnt == AWIDTH'(DEPTH - 1)) w_state_next = ST_READY;
      end
      ST_READY: begin
        w_mem_we = w_wr_accept;
      end
      default: w_state_next = ST_READY;
    endcase
    w_ready_next = (w_state_next == ST_READY);
  end

  // Byte-masked memory write.
  // NOTE: the array has no reset; deterministic contents come from the clear sequencer.
  always_ff @(posedge clock) begin
    if (reset_n && w_mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_addr][8*b +: 8] <= w_mem_din[8*b +: 8];
      end
    end
  end

  // Word presented to the read register; in write-through mode a same-address
  // write is merged byte-wise on top of the stored word.
  // NOTE: the write above is non-blocking, so reading r_mem here on the same edge yields the pre-write word.
  always_comb begin
    w_rd_word = r_mem[bus.rd_addr];
    if ((RDW_MODE != 0) && w_wr_accept && (bus.wr_addr == bus.rd_addr)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.wr_be[b]) w_rd_word[8*b +: 8] = bus.din[8*b +: 8];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DWIDTH-1:0] r_pipe_data;
      logic              r_pipe_valid;

      // Two-stage read: array register, then output register; no stall.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_pipe_data  <= '0;
          r_pipe_valid <= 1'b0;
          r_dout       <= '0;
          r_rd_valid   <= 1'b0;
        end else begin
          r_pipe_valid <= w_rd_accept;
          if (w_rd_accept) r_pipe_data <= w_rd_word;
          r_rd_valid   <= r_pipe_valid;
          if (r_pipe_valid) r_dout <= r_pipe_data;
        end
      end
    end else begin : g_no_out_reg
      // Single-stage read; dout only moves when a read completes.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_dout     <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_accept;
          if (w_rd_accept) r_dout <= w_rd_word;
        end
      end
    end
  endgenerate

  assign bus.dout     = r_dout;
  assign bus.rd_valid = r_rd_valid;
  assign bus.ready    = r_ready;
endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Directed bench for ram_sync_dp_be. Three instances share one stimulus:
//   dut0: RDW_MODE=0, OUT_REG=0, clear to A5A5A5A5
//   dut1: RDW_MODE=1, OUT_REG=1, clear to A5A5A5A5
//   dut2: CLEAR_ON_RESET=0, RDW_MODE=0, OUT_REG=0
// Inputs change and outputs are sampled on the falling edge.
module tb_ram_sync_dp_be;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] din;
  logic        rd_en;
  logic [2:0]  rd_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ram_sync_dp_be_if #(.AWIDTH(3), .DWIDTH(32)) if0 ();
  ram_sync_dp_be_if #(.AWIDTH(3), .DWIDTH(32)) if1 ();
  ram_sync_dp_be_if #(.AWIDTH(3), .DWIDTH(32)) if2 ();

  assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;  assign if0.wr_be = wr_be;
  assign if0.din   = din;    assign if0.rd_en   = rd_en;    assign if0.rd_addr = rd_addr;
  assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;  assign if1.wr_be = wr_be;
  assign if1.din   = din;    assign if1.rd_en   = rd_en;    assign if1.rd_addr = rd_addr;
  assign if2.wr_en = wr_en;  assign if2.wr_addr = wr_addr;  assign if2.wr_be = wr_be;
  assign if2.din   = din;    assign if2.rd_en   = rd_en;    assign if2.rd_addr = rd_addr;

  ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(0), .OUT_REG(0),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(INIT))
    dut0 (.clock(clock), .reset_n(reset_n), .bus(if0));
  ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(1), .OUT_REG(1),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(INIT))
    dut1 (.clock(clock), .reset_n(reset_n), .bus(if1));
  ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(0), .OUT_REG(0),
                   .CLEAR_ON_RESET(0), .INIT_VALUE(INIT))
    dut2 (.clock(clock), .reset_n(reset_n), .bus(if2));

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; din = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic test_reset();
    int rise0 = 0, rise1 = 0, rise2 = 0;
    reset_n = 1'b0; idle();
    tick(); tick();
    checks++; if ({if0.ready, if1.ready, if2.ready} !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b exp=000", {if0.ready, if1.ready, if2.ready}); end
    checks++; if ({if0.rd_valid, if1.rd_valid, if2.rd_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_rd_valid got=%b exp=000", {if0.rd_valid, if1.rd_valid, if2.rd_valid}); end
    checks++; if ({if0.dout, if1.dout, if2.dout} !== 96'h0) begin
      failures++; $display("FAIL reset_dout got=%h exp=0", {if0.dout, if1.dout, if2.dout}); end
    reset_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (if0.ready && rise0 == 0) rise0 = c;
      if (if1.ready && rise1 == 0) rise1 = c;
      if (if2.ready && rise2 == 0) rise2 = c;
    end
    checks++; if (rise0 !== 8) begin failures++; $display("FAIL clear_len0 got=%0d exp=8", rise0); end
    checks++; if (rise1 !== 8) begin failures++; $display("FAIL clear_len1 got=%0d exp=8", rise1); end
    checks++; if (rise2 !== 1) begin failures++; $display("FAIL noclear_ready got=%0d exp=1", rise2); end
  endtask

  task automatic test_clear_contents();
    for (int c = 0; c < 10; c++) begin
      rd_en = (c < 8); rd_addr = 3'(c);
      tick();
      checks++; if ({if0.rd_valid, if0.dout} !== {(c < 8), INIT}) begin
        failures++; $display("FAIL clear_rd0 c=%0d got=%b/%h exp=%b/%h", c, if0.rd_valid, if0.dout, (c < 8), INIT); end
      checks++; if ({if1.rd_valid, if1.dout} !== {(c >= 1 && c <= 8), (c == 0) ? 32'h0 : INIT}) begin
        failures++; $display("FAIL clear_rd1 c=%0d got=%b/%h", c, if1.rd_valid, if1.dout); end
    end
    idle();
  endtask

  task automatic test_byte_enables();
    wr_en = 1'b1; wr_addr = 3'd3; din = 32'h11223344; wr_be = 4'hF; tick();
    din = 32'hAABBCCDD; wr_be = 4'b0101; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd3; tick();
    checks++; if ({if0.rd_valid, if0.dout} !== {1'b1, 32'h11BB33DD}) begin
      failures++; $display("FAIL be_merge0 got=%b/%h exp=1/11bb33dd", if0.rd_valid, if0.dout); end
    checks++; if ({if2.rd_valid, if2.dout} !== {1'b1, 32'h11BB33DD}) begin
      failures++; $display("FAIL be_merge2 got=%b/%h exp=1/11bb33dd", if2.rd_valid, if2.dout); end
    rd_en = 1'b0; tick();
    checks++; if ({if1.rd_valid, if1.dout} !== {1'b1, 32'h11BB33DD}) begin
      failures++; $display("FAIL be_merge1 got=%b/%h exp=1/11bb33dd", if1.rd_valid, if1.dout); end
    wr_en = 1'b1; din = 32'hFFFFFFFF; wr_be = 4'h0; tick();
    wr_en = 1'b0; rd_en = 1'b1; tick();
    checks++; if ({if0.rd_valid, if0.dout} !== {1'b1, 32'h11BB33DD}) begin
      failures++; $display("FAIL be_zero0 got=%b/%h exp=1/11bb33dd", if0.rd_valid, if0.dout); end
    rd_en = 1'b0; tick();
    checks++; if ({if1.rd_valid, if1.dout} !== {1'b1, 32'h11BB33DD}) begin
      failures++; $display("FAIL be_zero1 got=%b/%h exp=1/11bb33dd", if1.rd_valid, if1.dout); end
    idle();
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 3'd5; din = 32'h0; wr_be = 4'hF; tick();
    din = 32'hDEADBEEF; rd_en = 1'b1; rd_addr = 3'd5; tick();
    checks++; if ({if0.rd_valid, if0.dout} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL rdw_old0 got=%b/%h exp=1/0", if0.rd_valid, if0.dout); end
    checks++; if ({if2.rd_valid, if2.dout} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL rdw_old2 got=%b/%h exp=1/0", if2.rd_valid, if2.dout); end
    wr_en = 1'b0; tick();
    checks++; if ({if0.rd_valid, if0.dout} !== {1'b1, 32'hDEADBEEF}) begin
      failures++; $display("FAIL rdw_next0 got=%b/%h exp=1/deadbeef", if0.rd_valid, if0.dout); end
    checks++; if ({if1.rd_valid, if1.dout} !== {1'b1, 32'hDEADBEEF}) begin
      failures++; $display("FAIL rdw_new1 got=%b/%h exp=1/deadbeef", if1.rd_valid, if1.dout); end
    rd_en = 1'b0; tick();
    checks++; if ({if1.rd_valid, if1.dout} !== {1'b1, 32'hDEADBEEF}) begin
      failures++; $display("FAIL rdw_next1 got=%b/%h exp=1/deadbeef", if1.rd_valid, if1.dout); end
    checks++; if ({if0.rd_valid, if0.dout} !== {1'b0, 32'hDEADBEEF}) begin
      failures++; $display("FAIL hold0 got=%b/%h exp=0/deadbeef", if0.rd_valid, if0.dout); end
    // Partial-byte collision: write-through merges only the enabled bytes.
    wr_en = 1'b1; din = 32'h12345678; wr_be = 4'b0011; rd_en = 1'b1; tick();
    checks++; if ({if0.rd_valid, if0.dout} !== {1'b1, 32'hDEADBEEF}) begin
      failures++; $display("FAIL rdw_part0 got=%b/%h exp=1/deadbeef", if0.rd_valid, if0.dout); end
    wr_en = 1'b0; rd_en = 1'b0; tick();
    checks++; if ({if1.rd_valid, if1.dout} !== {1'b1, 32'hDEAD5678}) begin
      failures++; $display("FAIL rdw_part1 got=%b/%h exp=1/dead5678", if1.rd_valid, if1.dout); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp0, exp1;
    int          k;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); din = 32'hC0DE0000 | 32'(i); wr_be = 4'hF; tick();
    end
    idle();
    for (int c = 0; c < 11; c++) begin
      rd_en = (c < 8); rd_addr = 3'(c);
      // Independent write to an address already read.
      wr_en = (c >= 1 && c <= 8); wr_addr = 3'(c - 1); din = 32'h5A5A0000 | 32'(c); wr_be = 4'hF;
      tick();
      exp0 = 32'hC0DE0000 | 32'((c < 8) ? c : 7);
      k    = (c - 1 > 7) ? 7 : c - 1;
      exp1 = (c == 0) ? 32'hDEAD5678 : (32'hC0DE0000 | 32'(k));
      checks++; if ({if0.rd_valid, if0.dout} !== {(c < 8), exp0}) begin
        failures++; $display("FAIL b2b0 c=%0d got=%b/%h exp=%b/%h", c, if0.rd_valid, if0.dout, (c < 8), exp0); end
      checks++; if ({if1.rd_valid, if1.dout} !== {(c >= 1 && c <= 8), exp1}) begin
        failures++; $display("FAIL b2b1 c=%0d got=%b/%h exp=%b/%h", c, if1.rd_valid, if1.dout, (c >= 1 && c <= 8), exp1); end
    end
    idle();
    rd_en = 1'b1; rd_addr = 3'd0; tick();
    checks++; if ({if0.rd_valid, if0.dout} !== {1'b1, 32'h5A5A0001}) begin
      failures++; $display("FAIL indep_wr0 got=%b/%h exp=1/5a5a0001", if0.rd_valid, if0.dout); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_op();
    int rise0 = 0, rise1 = 0;
    rd_en = 1'b1; rd_addr = 3'd1; tick();
    rd_addr = 3'd2; tick();
    reset_n = 1'b0; rd_addr = 3'd3; tick();
    checks++; if ({if0.rd_valid, if1.rd_valid, if0.dout, if1.dout} !== 66'h0) begin
      failures++; $display("FAIL rst_inflight got=%b%b/%h/%h exp=00/0/0", if0.rd_valid, if1.rd_valid, if0.dout, if1.dout); end
    tick();
    checks++; if ({if0.rd_valid, if1.rd_valid, if0.ready, if1.ready, if2.ready} !== 5'b0) begin
      failures++; $display("FAIL rst_hold got=%b exp=00000", {if0.rd_valid, if1.rd_valid, if0.ready, if1.ready, if2.ready}); end
    // Release, then requests during the first half of CLEAR must be ignored.
    reset_n = 1'b1;
    wr_en = 1'b1; wr_be = 4'hF; din = 32'h0BAD0BAD; rd_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      wr_addr = 3'(c); rd_addr = 3'(c); tick();
      checks++; if ({if0.rd_valid, if1.rd_valid, if0.ready, if1.ready} !== 4'b0) begin
        failures++; $display("FAIL clr_ignore c=%0d got=%b exp=0000", c, {if0.rd_valid, if1.rd_valid, if0.ready, if1.ready}); end
    end
    // Reset at clear counter 4 restarts the sequence from address 0.
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      wr_addr = 3'(c + 2); rd_addr = 3'(c);
      tick();
      if (c == 1) begin
        checks++; if (if2.ready !== 1'b1) begin
          failures++; $display("FAIL noclear_ready2 got=%b exp=1", if2.ready); end
      end
      checks++; if ({if0.rd_valid, if1.rd_valid} !== 2'b00) begin
        failures++; $display("FAIL clr_novalid c=%0d got=%b exp=00", c, {if0.rd_valid, if1.rd_valid}); end
      if (if0.ready && rise0 == 0) rise0 = c;
      if (if1.ready && rise1 == 0) rise1 = c;
      if (if0.ready || if1.ready) idle();
    end
    checks++; if (rise0 !== 8) begin failures++; $display("FAIL reclear_len0 got=%0d exp=8", rise0); end
    checks++; if (rise1 !== 8) begin failures++; $display("FAIL reclear_len1 got=%0d exp=8", rise1); end
    for (int c = 0; c < 9; c++) begin
      rd_en = (c < 8); rd_addr = 3'(c); tick();
      if (c < 8) begin
        checks++; if ({if0.rd_valid, if0.dout} !== {1'b1, INIT}) begin
          failures++; $display("FAIL reclear_rd0 c=%0d got=%b/%h exp=1/%h", c, if0.rd_valid, if0.dout, INIT); end
      end
      if (c >= 1) begin
        checks++; if ({if1.rd_valid, if1.dout} !== {1'b1, INIT}) begin
          failures++; $display("FAIL reclear_rd1 c=%0d got=%b/%h exp=1/%h", c, if1.rd_valid, if1.dout, INIT); end
      end
    end
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_clear_contents();
    test_byte_enables();
    test_collision();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
